// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable sample delay built on a circular buffer.
// One RAM of MAX_DELAY entries, a write pointer, and a read address derived
// from the write pointer minus the active delay. State only advances on input
// strobes. After a delay load the line refills for D strobes before its
// outputs are flagged valid, so stale memory never reaches downstream logic.
//
// Optional build macro: PROG_DELAY_ZERO_FILL_EN -- while filling, emit valid
// zero samples, so the line behaves like a zero-initialised shift register.
//
// Ports:
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   data_in_valid   sample strobe, one sample per high cycle
//   data_in         input sample
//   delay           requested delay D (legal 1..MAX_DELAY, clamped otherwise)
//   delay_load      one-cycle pulse: latch delay, restart fill
//   data_out        delayed sample, held between strobes
//   data_out_valid  one-cycle pulse when data_out is a genuine delayed sample
//   primed          high while in RUN
//   delay_err       one-cycle pulse after an out-of-range load
//
// state | meaning
// FILL  | buffer refilling after reset/load; outputs not yet genuine
// RUN   | fill complete; output for strobe n is input of strobe n-D
module prog_delay_line #(
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_DELAY  = 4999,
  localparam int ADDR_WIDTH = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  delay_load,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  primed,
  output logic                  delay_err
);

  // Memory index width; narrower than ADDR_WIDTH when MAX_DELAY is a power of two.
  localparam int IDX_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_D    = ADDR_WIDTH'(MAX_DELAY);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MAX_DELAY - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt, st_base;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]   cur_d, cur_d_nxt;
  logic [ADDR_WIDTH-1:0]   fill_cnt, fill_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   load_d, d_eff, fill_base;
  logic [IDX_W-1:0]        rd_idx;
  logic                    load_bad, out_valid_nxt, zero_out;
  logic [DATA_WIDTH-1:0]   mem [MAX_DELAY];

  always_comb begin
    load_bad = (delay == '0) || (delay > MAX_D);
    load_d   = delay;
    if (delay == '0)       load_d = ONE;
    else if (delay > MAX_D) load_d = MAX_D;

    // A load takes effect before a coincident strobe is processed.
    d_eff     = delay_load ? load_d : cur_d;
    fill_base = delay_load ? '0 : fill_cnt;
    st_base   = delay_load ? FILL : state;

    // wr_ptr - d modulo MAX_DELAY; d == MAX_DELAY lands on wr_ptr itself,
    // and the write-after-read ordering returns the old contents.
    rd_idx = IDX_W'((wr_ptr < d_eff) ? (wr_ptr + (MAX_D - d_eff)) : (wr_ptr - d_eff));

    cur_d_nxt     = d_eff;
    fill_cnt_nxt  = fill_base;
    state_nxt     = st_base;
    wr_ptr_nxt    = wr_ptr;
    out_valid_nxt = 1'b0;
    zero_out      = 1'b0;

    if (data_in_valid) begin
      wr_ptr_nxt   = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ONE;
      fill_cnt_nxt = (fill_base >= d_eff) ? d_eff : fill_base + ONE;
      if (fill_cnt_nxt == d_eff) state_nxt = RUN;
`ifdef PROG_DELAY_ZERO_FILL_EN
      out_valid_nxt = 1'b1;
      zero_out      = (st_base == FILL);
`else
      out_valid_nxt = (st_base == RUN);
`endif
    end
  end

  // Sample storage carries no reset.
  always_ff @(posedge clock) begin
    if (data_in_valid) mem[wr_ptr[IDX_W-1:0]] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FILL;
      wr_ptr         <= '0;
      cur_d          <= MAX_D;
      fill_cnt       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      delay_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      wr_ptr         <= wr_ptr_nxt;
      cur_d          <= cur_d_nxt;
      fill_cnt       <= fill_cnt_nxt;
      data_out_valid <= out_valid_nxt;
      delay_err      <= delay_load && load_bad;
      if (data_in_valid) data_out <= zero_out ? '0 : mem[rd_idx];
    end
  end

  assign primed = (state == RUN);

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboarded bench for prog_delay_line (MAX_DELAY=8). A reference model
// keeps the full input history since reset and the strobe count since the last
// load; a valid output for strobe n is history[n-D].
module tb_prog_delay_line;
  localparam int DW   = 16;
  localparam int MAXD = 8;
  localparam int AW   = 4;
`ifdef PROG_DELAY_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          data_in_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] delay = '0;
  logic          delay_load = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          primed;
  logic          delay_err;

  prog_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MAXD)) dut (
    .clock(clock), .reset_n(reset_n), .data_in_valid(data_in_valid),
    .data_in(data_in), .delay(delay), .delay_load(delay_load),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .primed(primed), .delay_err(delay_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] hist[$];
  int            m_d, m_k;
  logic          exp_primed, exp_err, known;
  logic [DW-1:0] known_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sb_q.delete();
    m_d = MAXD; m_k = 0;
    exp_primed = 1'b0; exp_err = 1'b0;
    known = 1'b1; known_val = '0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic ld, input int dl);
    exp_err = 1'b0;
    if (ld) begin
      if (dl == 0)         begin m_d = 1;    exp_err = 1'b1; end
      else if (dl > MAXD)  begin m_d = MAXD; exp_err = 1'b1; end
      else                 m_d = dl;
      m_k = 0;
      exp_primed = 1'b0;
    end
    if (v) begin
      logic [DW-1:0] e;
      int n;
      hist.push_back(d);
      m_k++;
      n = hist.size();
      if (m_k - 1 >= m_d) begin
        e = hist[n - 1 - m_d];
        sb_q.push_back(e);
        known = 1'b1; known_val = e;
      end else if (ZF) begin
        sb_q.push_back('0);
        known = 1'b1; known_val = '0;
      end else begin
        known = 1'b0;
      end
      if (m_k >= m_d) exp_primed = 1'b1;
    end
  endtask

  task automatic check_state();
    chk("primed", primed, exp_primed);
    chk("delay_err", delay_err, exp_err);
    if (known) chk("data_out_hold", data_out, known_val);
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d, input logic ld, input int dl);
    @(negedge clock);
    check_state();
    data_in_valid = v;
    data_in       = d;
    delay_load    = ld;
    delay         = AW'(dl);
    model_step(v, d, ld, dl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 0);
  endtask

  task automatic reset_now();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_primed", primed, 0);
    chk("rst_delay_err", delay_err, 0);
    @(negedge clock);
    data_in_valid = 1'b0; delay_load = 1'b0; data_in = '0; delay = '0;
    reset_n = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && data_out_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got data %0h expected no output at %0t", data_out, $time);
      end else begin
        chk("sb_data", data_out, sb_q.pop_front());
      end
    end
  end

  initial begin
    reset_now();

    // Fill and first valid output.
    tick(1'b0, '0, 1'b1, 3);
    for (int i = 1; i <= 5; i++) tick(1'b1, DW'(i), 1'b0, 0);
    idle(2);

    // Maximum delay, wrapping with same-address read-first.
    tick(1'b0, '0, 1'b1, 8);
    for (int i = 1; i <= 20; i++) tick(1'b1, DW'(i), 1'b0, 0);
    idle(2);

    // Reprogram in RUN with a load coincident with a strobe.
    tick(1'b0, '0, 1'b1, 3);
    for (int i = 0; i < 6; i++) tick(1'b1, DW'($urandom), 1'b0, 0);
    tick(1'b1, DW'($urandom), 1'b1, 5);
    for (int i = 0; i < 10; i++) tick(1'b1, DW'($urandom), 1'b0, 0);
    idle(2);

    // Out-of-range loads clamp to 1 and MAX_DELAY.
    tick(1'b0, '0, 1'b1, 0);
    for (int i = 0; i < 5; i++) tick(1'b1, DW'($urandom), 1'b0, 0);
    tick(1'b0, '0, 1'b1, 9);
    for (int i = 0; i < 12; i++) tick(1'b1, DW'($urandom), 1'b0, 0);
    idle(2);

    // Gapped strobes, then reset in the middle of a valid output.
    tick(1'b0, '0, 1'b1, 2);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, DW'($urandom), 1'b0, 0);
      idle(2);
    end
    tick(1'b1, DW'($urandom), 1'b0, 0);
    @(posedge clock);
    #2;
    reset_now();
    idle(2);

    // Short-delay stream matching the zero-fill scenario.
    tick(1'b0, '0, 1'b1, 3);
    for (int i = 7; i <= 10; i++) tick(1'b1, DW'(i), 1'b0, 0);
    idle(2);

    // Random traffic with occasional loads, including illegal values.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 6), DW'($urandom),
           ($urandom_range(0, 29) == 0), int'($urandom_range(0, 15)));
    end
    idle(3);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

- Parametrised, runtime-programmable sample delay line for the pico_ctrl datapath.
- Replaces the fixed 16-bit × 4999-stage register chain with a circular buffer (one RAM, read/write pointers).
- Only clocks on input strobes; delay is reprogrammable in service; a fill state keeps stale memory out of the output.
- Sits between the sample source and downstream filter/compare logic that needs a delayed copy of the stream.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width in bits.
- MAX_DELAY, 4999, buffer depth and largest legal delay, in samples.
- ADDR_WIDTH, derived as $clog2(MAX_DELAY+1); not overridden by users. The +1 lets delay and fill_cnt hold the value MAX_DELAY even when it is a power of two.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in_valid  in  1  sample strobe; one sample accepted per high cycle.
- data_in  in  DATA_WIDTH  input sample.
- delay  in  ADDR_WIDTH  requested delay D in samples; legal range 1..MAX_DELAY.
- delay_load  in  1  single-cycle pulse; latches `delay` and restarts fill.
- data_out  out  DATA_WIDTH  delayed sample; held between strobes.
- data_out_valid  out  1  one-cycle pulse; data_out is a genuine delayed sample.
- primed  out  1  high in RUN state.
- delay_err  out  1  one-cycle pulse; the last load was out of range and was clamped.

## Operation
- Storage: mem[0..MAX_DELAY-1] of DATA_WIDTH. No reset on memory. Read-first semantics when the read and write address are the same.
- Registers:
  - wr_ptr: 0..MAX_DELAY-1; wraps MAX_DELAY-1 → 0.
  - cur_d: active delay.
  - fill_cnt: 0..cur_d, saturating.
  - state: FILL or RUN.
- Read address:
  - rd_addr = wr_ptr − cur_d, taken modulo MAX_DELAY.
  - If wr_ptr < cur_d, rd_addr = wr_ptr + MAX_DELAY − cur_d.
  - If cur_d = MAX_DELAY, rd_addr = wr_ptr; the old contents are read.
- On each strobe (data_in_valid=1):
  - mem[wr_ptr] ← data_in; wr_ptr advances.
  - data_out ← mem[rd_addr].
  - data_out_valid ← (state==RUN).
  - fill_cnt increments, saturating at cur_d.
- Result: in RUN, the output for strobe n equals the input of strobe n−D.
- FILL → RUN: on the strobe where fill_cnt reaches cur_d. That strobe still outputs invalid data. The first valid output is on strobe D+1 and carries sample 1.
- delay_load:
  - cur_d ← clamp(delay, 1, MAX_DELAY).
  - fill_cnt ← 0; state ← FILL; wr_ptr is unchanged.
  - delay_err pulses if delay==0 or delay>MAX_DELAY.
- delay_load together with data_in_valid:
  - The load applies first; the strobe is then processed with the new cur_d.
  - That strobe counts as fill sample 1 (fill_cnt=1 afterwards), and its output is invalid.
- No strobe: all state holds; data_out holds; data_out_valid=0.

## Timing
- Latency: data_out and data_out_valid update on the clock edge after the strobe cycle (1-cycle registered). Measured in samples, the delay is exactly D strobes.
- Reset (asynchronous assert, any time, including mid-stream):
  - data_out=0, data_out_valid=0, primed=0, delay_err=0.
  - wr_ptr=0, fill_cnt=0, cur_d=MAX_DELAY, state=FILL.
- Reset release: the first strobe is accepted on the first rising edge with reset_n=1.
- Back-to-back strobes every cycle are supported at full rate.
- primed falls on the edge that applies delay_load, and rises on the edge of the strobe that completes the fill.

## Configuration
- PROG_DELAY_ZERO_FILL_EN defined:
  - While in FILL, each strobe outputs data_out=0 with data_out_valid=1.
  - The stream therefore looks like a zero-initialised shift register, matching the legacy fixed delay chain.
  - primed still reports FILL/RUN.
- Not defined: in FILL, data_out_valid=0 and data_out takes the raw memory value; downstream logic must not use it.

## Test plan
- Fill and first valid output (MAX_DELAY=8, reset, delay_load D=3, strobes carrying 1,2,3,4,5 every cycle): no valid outputs for the first three strobes; valid outputs 1, 2 follow strobes 4 and 5; primed rises with strobe 3.
- Wrap-around (D=8=MAX_DELAY, 20 strobes carrying 1..20): outputs 1..12 appear valid after strobes 9..20; this checks same-address read-first behaviour.
- Reprogramming in RUN (D=3 then D=5, with delay_load coincident with a strobe): primed drops; five strobes are invalid; then output equals input delayed by exactly 5.
- Out-of-range loads (delay=0, then delay=9): delay_err pulses once per load; the delays behave as 1 and 8 respectively.
- Gapped strobes and mid-stream reset (strobes every third cycle, D=2): outputs hold between strobes and data_out_valid is 1 cycle wide; asserting reset_n=0 mid-stream forces all outputs to 0 immediately.
- With PROG_DELAY_ZERO_FILL_EN defined (D=3, inputs 7,8,9,10): outputs 0,0,0,7, all valid.
